// File: rtl/judge_ctrl.sv
// judge_ctrl: per-lane pending-note slots, hit/timeout judgment and a
// single serialised score/combo accumulator for the 4-lane rhythm game.
module judge_ctrl #(
  parameter int PERFECT_WIN = 40,
  parameter int GOOD_WIN    = 90,
  parameter int MISS_WIN    = 150,
  parameter int PERFECT_PTS = 300,
  parameter int GOOD_PTS    = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ms_tick,
  input  logic        start,
  input  logic        chart_end,
  input  logic [3:0]  lane_key,
  input  logic        note_valid,
  input  logic [1:0]  note_lane,
  input  logic [19:0] note_time,
  output logic        note_ready,
  output logic        playing,
  output logic        done,
  output logic [19:0] song_time,
  output logic        judge_valid,
  output logic [1:0]  judge_lane,
  output logic [1:0]  judge_kind,
  output logic [31:0] score,
  output logic [15:0] combo,
  output logic [15:0] max_combo
);

  localparam logic [19:0] P_WIN = 20'(PERFECT_WIN);
  localparam logic [19:0] G_WIN = 20'(GOOD_WIN);
  localparam logic [19:0] M_WIN = 20'(MISS_WIN);
  localparam logic [32:0] P_PTS = 33'(PERFECT_PTS);
  localparam logic [32:0] G_PTS = 33'(GOOD_PTS);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  state_t      state;
  logic [3:0]  slot_full;
  logic [3:0]  pending;
  logic [3:0]  key_prev;
  logic [3:0]  press;
  logic [3:0]  set;
  logic [3:0]  load;
  logic [3:0]  grant;
  logic [3:0]  tmo;
  logic [19:0] slot_time [4];
  logic [19:0] diff      [4];
  logic [1:0]  pend_kind [4];
  logic [1:0]  set_kind  [4];
  logic        end_seen;
  logic [1:0]  g_lane;
  logic [32:0] score_sum;
  logic [15:0] combo_nxt;

  assign note_ready = playing
                    & ~slot_full[note_lane]
                    & ~pending[note_lane];

  assign press = lane_key & ~key_prev & {4{playing}};

  assign load = (note_valid & note_ready)
              ? (4'b0001 << note_lane)
              : 4'b0000;

  // A press on a full slot decides the lane; the timeout only
  // applies on cycles without a fresh press edge.
  always_comb begin
    set = '0;
    tmo = '0;
    for (int i = 0; i < 4; i++) begin
      diff[i] = (song_time >= slot_time[i])
              ? song_time - slot_time[i]
              : slot_time[i] - song_time;
      tmo[i] = {1'b0, song_time} >
               ({1'b0, slot_time[i]} + 21'(MISS_WIN));
      set_kind[i] = 2'd2;
      if (diff[i] <= P_WIN)
        set_kind[i] = 2'd0;
      else if (diff[i] <= G_WIN)
        set_kind[i] = 2'd1;
      if (slot_full[i])
        set[i] = press[i] ? (diff[i] <= M_WIN) : tmo[i];
    end
  end

  assign grant = pending & (~pending + 4'd1);

  always_comb begin
    g_lane = 2'd0;
    unique case (1'b1)
      grant[0]: g_lane = 2'd0;
      grant[1]: g_lane = 2'd1;
      grant[2]: g_lane = 2'd2;
      grant[3]: g_lane = 2'd3;
      default:  g_lane = 2'd0;
    endcase
  end

  always_comb begin
    score_sum = {1'b0, score}
              + ((pend_kind[g_lane] == 2'd0) ? P_PTS : G_PTS);
    combo_nxt = (combo == 16'hFFFF) ? combo : combo + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      playing     <= 1'b0;
      done        <= 1'b0;
      song_time   <= '0;
      slot_full   <= '0;
      pending     <= '0;
      key_prev    <= '0;
      end_seen    <= 1'b0;
      judge_valid <= 1'b0;
      judge_lane  <= '0;
      judge_kind  <= '0;
      score       <= '0;
      combo       <= '0;
      max_combo   <= '0;
    end else if (start) begin
      state       <= PLAY;
      playing     <= 1'b1;
      done        <= 1'b0;
      song_time   <= '0;
      slot_full   <= '0;
      pending     <= '0;
      key_prev    <= '0;
      end_seen    <= 1'b0;
      judge_valid <= 1'b0;
      judge_lane  <= '0;
      judge_kind  <= '0;
      score       <= '0;
      combo       <= '0;
      max_combo   <= '0;
    end else begin
      key_prev    <= lane_key;
      judge_valid <= 1'b0;
      if (state == PLAY) begin
        if (ms_tick && song_time != 20'hFFFFF)
          song_time <= song_time + 20'd1;
        if (chart_end)
          end_seen <= 1'b1;
        if (end_seen && slot_full == '0 && pending == '0) begin
          state   <= DONE;
          playing <= 1'b0;
          done    <= 1'b1;
        end
        slot_full <= (slot_full & ~set) | load;
        pending   <= (pending & ~grant) | set;
        for (int i = 0; i < 4; i++) begin
          if (set[i])
            pend_kind[i] <= set_kind[i];
          if (load[i])
            slot_time[i] <= note_time;
        end
        if (|grant) begin
          judge_valid <= 1'b1;
          judge_lane  <= g_lane;
          judge_kind  <= pend_kind[g_lane];
          if (pend_kind[g_lane] == 2'd2) begin
            combo <= '0;
          end else begin
            score <= score_sum[32] ? 32'hFFFF_FFFF : score_sum[31:0];
            combo <= combo_nxt;
            if (combo_nxt > max_combo)
              max_combo <= combo_nxt;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_judge_ctrl.sv
// tb_judge_ctrl: directed scenarios plus randomized play checked
// against a behavioural model of notes, judgments and scoring.
module tb_judge_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ms_tick = 1'b0;
  logic        start = 1'b0;
  logic        chart_end = 1'b0;
  logic [3:0]  lane_key = '0;
  logic        note_valid = 1'b0;
  logic [1:0]  note_lane = '0;
  logic [19:0] note_time = '0;
  logic        note_ready;
  logic        playing;
  logic        done;
  logic [19:0] song_time;
  logic        judge_valid;
  logic [1:0]  judge_lane;
  logic [1:0]  judge_kind;
  logic [31:0] score;
  logic [15:0] combo;
  logic [15:0] max_combo;

  always #5 clk = ~clk;

  judge_ctrl dut (
    .clk(clk), .rst(rst), .ms_tick(ms_tick), .start(start),
    .chart_end(chart_end), .lane_key(lane_key),
    .note_valid(note_valid), .note_lane(note_lane),
    .note_time(note_time), .note_ready(note_ready),
    .playing(playing), .done(done), .song_time(song_time),
    .judge_valid(judge_valid), .judge_lane(judge_lane),
    .judge_kind(judge_kind), .score(score), .combo(combo),
    .max_combo(max_combo)
  );

  int passed = 0;
  int total  = 0;

  // behavioural model: 0 idle, 1 play, 2 done
  int       m_state;
  int       m_time;
  int       m_nt   [4];
  bit       m_full [4];
  bit       m_pend [4];
  int       m_kind [4];
  bit [3:0] m_prev;
  bit       m_end;
  bit       m_jv;
  int       m_jl, m_jk;
  longint   m_score;
  int       m_combo, m_max;

  task automatic m_clear();
    m_time = 0;
    m_full = '{default: 0};
    m_pend = '{default: 0};
    m_prev = '0;
    m_end = 0;
    m_jv = 0;
    m_score = 0;
    m_combo = 0;
    m_max = 0;
  endtask

  always @(posedge clk) begin
    int r, d;
    bit fin, pr, rdy;
    bit fl [4];
    bit pd [4];
    if (rst) begin
      m_clear();
      m_state = 0;
    end else if (start) begin
      m_clear();
      m_state = 1;
    end else begin
      m_jv = 0;
      if (m_state == 1) begin
        fl = m_full;
        pd = m_pend;
        fin = m_end;
        for (int i = 0; i < 4; i++)
          if (fl[i] || pd[i]) fin = 0;
        rdy = !fl[note_lane] && !pd[note_lane];
        r = -1;
        for (int i = 0; i < 4; i++)
          if (pd[i] && r < 0) r = i;
        if (r >= 0) begin
          m_jv = 1; m_jl = r; m_jk = m_kind[r]; m_pend[r] = 0;
          if (m_kind[r] == 2) m_combo = 0;
          else begin
            m_score += (m_kind[r] == 0) ? 300 : 100;
            if (m_score > 64'hFFFFFFFF) m_score = 64'hFFFFFFFF;
            if (m_combo < 65535) m_combo++;
            if (m_combo > m_max) m_max = m_combo;
          end
        end
        for (int i = 0; i < 4; i++) begin
          if (fl[i]) begin
            pr = lane_key[i] && !m_prev[i];
            d = m_time - m_nt[i];
            if (d < 0) d = -d;
            if (pr) begin
              if (d <= 150) begin
                m_full[i] = 0; m_pend[i] = 1;
                m_kind[i] = (d <= 40) ? 0 : (d <= 90) ? 1 : 2;
              end
            end else if (m_time > m_nt[i] + 150) begin
              m_full[i] = 0; m_pend[i] = 1; m_kind[i] = 2;
            end
          end
        end
        if (note_valid && rdy) begin
          m_full[note_lane] = 1;
          m_nt[note_lane] = note_time;
        end
        if (chart_end) m_end = 1;
        if (fin) m_state = 2;
        if (ms_tick && m_time < 20'hFFFFF) m_time++;
      end
      m_prev = lane_key;
    end
  end

  function automatic logic [90:0] got_v();
    return {playing, done, song_time, judge_valid,
            judge_valid ? judge_lane : 2'd0,
            judge_valid ? judge_kind : 2'd0,
            score, combo, max_combo};
  endfunction

  function automatic logic [90:0] exp_v();
    return {m_state == 1, m_state == 2, 20'(m_time), m_jv,
            m_jv ? 2'(m_jl) : 2'd0, m_jv ? 2'(m_jk) : 2'd0,
            32'(m_score), 16'(m_combo), 16'(m_max)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int t, output bit ok);
    ok = 0;
    for (int k = 0; k < 5000; k++) begin
      if (song_time == 20'(t)) begin
        ok = 1;
        break;
      end
      step();
    end
  endtask

  task automatic do_start();
    start = 1; step(); start = 0;
  endtask

  task automatic test_reset();
    rst = 1; ms_tick = 1;
    repeat (3) step();
    total++;
    if ({playing, done, song_time, judge_valid, judge_lane, judge_kind,
         score, combo, max_combo} !== '0)
      $display("FAIL reset_outs got=%h required=0",
               {playing, done, song_time, judge_valid, score, combo});
    else passed++;
    note_valid = 1; #1;
    total++;
    if (note_ready !== 1'b0)
      $display("FAIL reset_ready got=%b required=0", note_ready);
    else passed++;
    note_valid = 0;
    rst = 0;
    repeat (4) step();
    total++;
    if (playing !== 1'b0 || song_time !== 20'd0)
      $display("FAIL idle_hold got=%b/%0d required=0/0",
               playing, song_time);
    else passed++;
  endtask

  task automatic test_perfect();
    bit ok;
    do_start();
    total++;
    if (playing !== 1'b1 || song_time !== 20'd0)
      $display("FAIL start_tick got=%b/%0d required=1/0",
               playing, song_time);
    else passed++;
    note_valid = 1; note_lane = 0; note_time = 1000; #1;
    total++;
    if (note_ready !== 1'b1)
      $display("FAIL perf_ready got=%b required=1", note_ready);
    else passed++;
    step(); note_valid = 0;
    run_to(1020, ok);
    total++;
    if (!ok) $display("FAIL perf_wait got=%0d required=1020", song_time);
    else passed++;
    lane_key[0] = 1; step();
    total++;
    if (judge_valid !== 1'b0)
      $display("FAIL perf_latency got=%b required=0", judge_valid);
    else passed++;
    step();
    total++;
    if ({judge_valid, judge_lane, judge_kind} !== 5'b1_00_00 ||
        score !== 32'd300 || combo !== 16'd1)
      $display("FAIL perfect got=%b/%0d/%0d required=10000/300/1",
               {judge_valid, judge_lane, judge_kind}, score, combo);
    else passed++;
    total++;
    if (got_v() !== exp_v())
      $display("FAIL perf_model got=%h required=%h", got_v(), exp_v());
    else passed++;
    lane_key = 0;
  endtask

  task automatic test_good();
    bit ok;
    note_valid = 1; note_lane = 1; note_time = 2000; #1;
    total++;
    if (note_ready !== 1'b1)
      $display("FAIL good_ready got=%b required=1", note_ready);
    else passed++;
    step(); note_valid = 0;
    run_to(1800, ok);
    lane_key[1] = 1; step(); step();
    total++;
    if (!ok || judge_valid !== 1'b0 || score !== 32'd300)
      $display("FAIL early_ignored got=%b/%0d required=0/300",
               judge_valid, score);
    else passed++;
    #1;
    total++;
    if (note_ready !== 1'b0)
      $display("FAIL slot_kept got=%b required=0", note_ready);
    else passed++;
    lane_key[1] = 0;
    run_to(1920, ok);
    lane_key[1] = 1; step(); step();
    total++;
    if (!ok || {judge_valid, judge_lane, judge_kind} !== 5'b1_01_01 ||
        score !== 32'd400 || combo !== 16'd2 || max_combo !== 16'd2)
      $display("FAIL good got=%b/%0d/%0d required=10101/400/2",
               {judge_valid, judge_lane, judge_kind}, score, combo);
    else passed++;
    lane_key = 0;
  endtask

  task automatic test_timeout();
    bit ok, seen;
    do_start();
    note_valid = 1; note_lane = 0; note_time = 300; step();
    note_lane = 2; note_time = 500; step();
    note_valid = 0;
    run_to(300, ok);
    lane_key[0] = 1; step(); step();
    lane_key = 0;
    total++;
    if (!ok || combo !== 16'd1)
      $display("FAIL pre_miss_combo got=%0d required=1", combo);
    else passed++;
    seen = 0;
    for (int k = 0; k < 600 && !seen; k++) begin
      step();
      seen = judge_valid;
    end
    total++;
    if (!seen || song_time !== 20'd653 ||
        {judge_lane, judge_kind} !== 4'b10_10 ||
        combo !== 16'd0 || max_combo !== 16'd1 || score !== 32'd300)
      $display("FAIL timeout got=%b/%0d/%b/%0d/%0d required=1/653/1010/0/1",
               seen, song_time, {judge_lane, judge_kind}, combo, max_combo);
    else passed++;
    total++;
    if (got_v() !== exp_v())
      $display("FAIL timeout_model got=%h required=%h", got_v(), exp_v());
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_start();
    for (int l = 0; l < 4; l++) begin
      note_valid = 1; note_lane = 2'(l); note_time = 200; #1;
      total++;
      if (note_ready !== 1'b1)
        $display("FAIL b2b_ready lane=%0d got=%b required=1", l, note_ready);
      else passed++;
      step();
    end
    note_valid = 0;
    run_to(200, ok);
    lane_key = 4'hF; step();
    total++;
    if (!ok || judge_valid !== 1'b0)
      $display("FAIL b2b_first got=%b required=0", judge_valid);
    else passed++;
    for (int l = 0; l < 4; l++) begin
      step();
      total++;
      if (judge_valid !== 1'b1 || judge_lane !== 2'(l) ||
          judge_kind !== 2'd0)
        $display("FAIL b2b_order got=%b/%0d required=1/%0d",
                 judge_valid, judge_lane, l);
      else passed++;
    end
    total++;
    if (combo !== 16'd4 || score !== 32'd1200 || max_combo !== 16'd4)
      $display("FAIL b2b_combo got=%0d/%0d required=4/1200", combo, score);
    else passed++;
  endtask

  task automatic test_full_slot();
    bit ok, bad;
    note_valid = 1; note_lane = 3; note_time = 400; step();
    note_time = 500;
    bad = 0;
    repeat (20) begin
      step();
      if (note_ready !== 1'b0 || judge_valid !== 1'b0) bad = 1;
    end
    total++;
    if (bad)
      $display("FAIL held_full got=%b/%b required=0/0",
               note_ready, judge_valid);
    else passed++;
    lane_key[3] = 0;
    run_to(400, ok);
    lane_key[3] = 1; step();
    total++;
    if (!ok || note_ready !== 1'b0)
      $display("FAIL pend_block got=%b required=0", note_ready);
    else passed++;
    step();
    total++;
    if (judge_valid !== 1'b1 || judge_lane !== 2'd3 ||
        note_ready !== 1'b1 || combo !== 16'd5)
      $display("FAIL slot_release got=%b/%0d/%b/%0d required=1/3/1/5",
               judge_valid, judge_lane, note_ready, combo);
    else passed++;
    step(); note_valid = 0;
  endtask

  task automatic test_end_done();
    bit seen;
    chart_end = 1; step(); chart_end = 0;
    total++;
    if (playing !== 1'b1 || done !== 1'b0)
      $display("FAIL end_wait got=%b/%b required=1/0", playing, done);
    else passed++;
    seen = 0;
    for (int k = 0; k < 1000 && done !== 1'b1; k++) begin
      step();
      if (judge_valid && judge_lane == 2'd3 && judge_kind == 2'd2)
        seen = 1;
    end
    total++;
    if (!seen || done !== 1'b1 || playing !== 1'b0 ||
        song_time !== 20'd654)
      $display("FAIL done got=%b/%b/%0d required=1/1/654",
               seen, done, song_time);
    else passed++;
    repeat (5) step();
    total++;
    if (song_time !== 20'd654 || score !== 32'd1500 ||
        max_combo !== 16'd5 || combo !== 16'd0)
      $display("FAIL done_hold got=%0d/%0d/%0d required=654/1500/5",
               song_time, score, max_combo);
    else passed++;
    lane_key = 0;
    do_start();
    total++;
    if (score !== 0 || combo !== 0 || max_combo !== 0 ||
        playing !== 1'b1 || done !== 1'b0 || song_time !== 0)
      $display("FAIL restart got=%0d/%0d/%0d/%b required=0/0/0/1",
               score, combo, max_combo, playing);
    else passed++;
  endtask

  task automatic test_random();
    bit exp_rdy;
    do_start();
    for (int c = 0; c < 6000; c++) begin
      ms_tick = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 7) == 0) lane_key[i] = ~lane_key[i];
      note_valid = $urandom_range(0, 1) == 1;
      note_lane = 2'($urandom_range(0, 3));
      note_time = 20'(m_time + $urandom_range(0, 400));
      chart_end = ($urandom_range(0, 999) == 0);
      start = ($urandom_range(0, 1999) == 0) ||
              (m_state == 2 && $urandom_range(0, 49) == 0);
      #1;
      exp_rdy = (m_state == 1) && !m_full[note_lane] && !m_pend[note_lane];
      total++;
      if (note_ready !== exp_rdy)
        $display("FAIL rnd_ready c=%0d got=%b required=%b",
                 c, note_ready, exp_rdy);
      else passed++;
      step();
      total++;
      if (got_v() !== exp_v())
        $display("FAIL rnd_state c=%0d got=%h required=%h",
                 c, got_v(), exp_v());
      else passed++;
    end
    start = 0; chart_end = 0; note_valid = 0;
  endtask

  initial begin
    test_reset();
    test_perfect();
    test_good();
    test_timeout();
    test_back_to_back();
    test_full_slot();
    test_end_done();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/judge_ctrl.md
# judge_ctrl

Hit-judgment and scoring controller for the 4-lane rhythm game. Holds the next pending note per lane, accepts notes from the chart feeder with a valid/ready handshake, and judges key presses against the running song clock. Serialises all lane judgments through a single score/combo accumulator. Sits between the keyboard decoder, the chart reader and the score/combo display outputs of the top level.

## Interface
- PERFECT_WIN, 40: half-window in ms for a PERFECT judgment
- GOOD_WIN, 90: half-window in ms for a GOOD judgment
- MISS_WIN, 150: half-window in ms; a late note beyond this becomes a MISS
- PERFECT_PTS, 300: points added for a PERFECT
- GOOD_PTS, 100: points added for a GOOD

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- ms_tick  in  1  one-cycle pulse per millisecond
- start  in  1  one-cycle pulse; clears state and begins play
- chart_end  in  1  one-cycle pulse; feeder has no more notes
- lane_key  in  4  debounced key levels, bit i = lane i (a, s, k, l)
- note_valid  in  1  feeder offers a note
- note_lane  in  2  lane of offered note
- note_time  in  20  hit time of offered note, ms
- note_ready  out  1  note accepted this cycle if note_valid also high
- playing  out  1  high in PLAY
- done  out  1  high in DONE
- song_time  out  20  ms since start
- judge_valid  out  1  one-cycle pulse per judgment
- judge_lane  out  2  lane of judgment
- judge_kind  out  2  0 PERFECT, 1 GOOD, 2 MISS
- score  out  32  accumulated score
- combo  out  16  current combo
- max_combo  out  16  highest combo this song

## Operation
- States: IDLE, PLAY, DONE. Reset → IDLE. start in any state → clear song_time, slots, pending flags, score, combo, max_combo, key history → PLAY. PLAY → DONE when chart_end seen (latched) and all slots and pending flags empty. DONE holds results until start.
- song_time: increments on ms_tick in PLAY only; saturates at 0xFFFFF.
- Slot per lane: one entry (full flag + 20-bit time). note_ready = playing & ~slot_full[note_lane] & ~pending[note_lane]. Handshake completes when note_valid & note_ready; slot loaded at that edge.
- Press edge: lane_key[i] high and registered previous value low, in PLAY.
- Press on full slot: d = |song_time − note_time|. d ≤ PERFECT_WIN → PERFECT; d ≤ GOOD_WIN → GOOD; d ≤ MISS_WIN → MISS; otherwise press ignored, slot kept. On judgment: slot cleared, pending[i] set with kind.
- Press on empty slot or pending lane: ignored.
- Timeout: slot full and song_time > note_time + MISS_WIN (21-bit compare) → MISS pending, slot cleared.
- Press and timeout on same lane same cycle: press evaluation wins.
- Note acceptance and press on same lane same cycle: press sees empty slot, ignored; note loaded.
- Arbitration: one pending judgment retired per cycle, fixed priority lane 0 highest. Retire clears pending[i], pulses judge_valid with lane/kind.
- Scoring on retire: PERFECT/GOOD add points (saturate 0xFFFFFFFF), combo+1 (saturate 0xFFFF); MISS sets combo 0. max_combo = max(max_combo, new combo).

## Timing
- Reset values: note_ready 0, playing 0, done 0, song_time 0, judge_valid 0, judge_lane 0, judge_kind 0, score 0, combo 0, max_combo 0.
- All outputs registered except note_ready (combinational from state, slots, note_lane).
- Press latency: lane_key first sampled high at edge N → pending set at N → judge_valid, score, combo updated together at edge N+1 if no higher lane pending; each higher pending lane adds one cycle (max 3 extra).
- Timeout judged at the edge where song_time first exceeds note_time + MISS_WIN; retire next edge.
- start mid-play: all pending judgments discarded, no judge_valid emitted for them.
- ms_tick and start same cycle: start wins, song_time = 0.

## Test plan
- Reset, start, load note lane 0 at t=1000, press lane 0 at song_time 1020 → judge_valid, kind 0, score 300, combo 1.
- Note lane 1 at t=2000, press at 1920 → GOOD, score +100; press at 1800 on another note t=2000 → ignored, slot kept.
- Note lane 2 at t=500, no press → MISS at song_time 651, combo 0, max_combo unchanged.
- Notes in all 4 lanes at same time, all keys pressed same cycle → four judge_valid pulses on consecutive cycles, lanes 0,1,2,3; combo 4.
- note_valid lane 3 while slot 3 full → note_ready 0 until slot cleared; held key (no new edge) → no second judgment.
- chart_end with one slot full → stays PLAY until timeout MISS retires, then done=1; start → all counters 0, playing=1.
